// File: rtl/updown_digit_counter.sv
// Multi-digit up/down counter. Every digit counts modulo RADIX. Carry and
// borrow ripple through all digits within one cycle. The counter can either
// saturate or wrap at all-max and all-zero. Boundary attempts produce
// registered one-cycle overflow/underflow pulses.
module updown_digit_counter #(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10,
    parameter int WRAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  increase,
    input  logic                  decrease,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int         W    = 4 * DIGITS;
    localparam logic [3:0] DMAX = 4'(RADIX - 1);

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] clamp_val;
    logic [W-1:0] next_digits;
    logic         next_overflow;
    logic         next_underflow;
    logic         step_up;
    logic         step_down;

    // Boundary flags decoded straight from the registered digits.
    always_comb begin
        at_max = 1'b1;
        at_min = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] != DMAX) at_max = 1'b0;
            if (digits[4*i +: 4] != 4'd0) at_min = 1'b0;
        end
    end

    // Candidate values: +1 with carry ripple, -1 with borrow ripple, and the
    // per-digit clamped load value.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] cur;
        logic [3:0] lv;
        carry     = 1'b1;
        borrow    = 1'b1;
        cur       = 4'd0;
        lv        = 4'd0;
        inc_val   = '0;
        dec_val   = '0;
        clamp_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            cur = digits[4*i +: 4];
            lv  = load_value[4*i +: 4];
            if (carry) begin
                if (cur == DMAX) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cur + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                inc_val[4*i +: 4] = cur;
            end
            if (borrow) begin
                if (cur == 4'd0) begin
                    dec_val[4*i +: 4] = DMAX;
                end else begin
                    dec_val[4*i +: 4] = cur - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                dec_val[4*i +: 4] = cur;
            end
            clamp_val[4*i +: 4] = (lv > DMAX) ? DMAX : lv;
        end
    end

    // Opposing or absent step requests cancel to a hold.
    assign step_up   = increase & ~decrease;
    assign step_down = decrease & ~increase;

    // Next-state selection with priority clear > load > step.
    always_comb begin
        next_digits    = digits;
        next_overflow  = 1'b0;
        next_underflow = 1'b0;
        if (clear) begin
            next_digits = '0;
        end else if (en) begin
            if (load) begin
                next_digits = clamp_val;
            end else if (step_up) begin
                if (at_max) begin
                    next_overflow = 1'b1;
                    next_digits   = (WRAP != 0) ? '0 : digits;
                end else begin
                    next_digits = inc_val;
                end
            end else if (step_down) begin
                if (at_min) begin
                    next_underflow = 1'b1;
                    next_digits    = (WRAP != 0) ? {DIGITS{DMAX}} : digits;
                end else begin
                    next_digits = dec_val;
                end
            end
        end
    end

    // State and pulse registers; reset returns to zero immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            digits    <= next_digits;
            overflow  <= next_overflow;
            underflow <= next_underflow;
        end
    end

endmodule
